// File: rtl/pc_pkg.sv
// Shared types for the OTTER fetch-stage program-counter unit.
package pc_pkg;

    localparam int PC_SRC_W = 3;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SRC_PLUS   = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_MTVEC  = 3'd4,
        PC_SRC_MEPC   = 3'd5,
        PC_SRC_RAS    = 3'd6,
        PC_SRC_RSVD   = 3'd7
    } pc_src_t;

endpackage

// File: rtl/pc_gen_if.sv
// Control-in / address-out bundle between control unit, branch logic and pc_gen.
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
);
    logic                PC_LD;
    pc_src_t             PC_SEL;
    logic [PC_WIDTH-1:0] JALR;
    logic [PC_WIDTH-1:0] BRANCH;
    logic [PC_WIDTH-1:0] JAL;
    logic [PC_WIDTH-1:0] MTVEC;
    logic [PC_WIDTH-1:0] MEPC;
    logic                CALL;
    logic                RET;
    logic [PC_WIDTH-1:0] PC_OUT;
    logic [PC_WIDTH-1:0] PC_PLUS;
    logic [PC_WIDTH-1:0] PC_NEXT;
    logic [PC_WIDTH-1:0] RAS_TOP;
    logic                RAS_EMPTY;
    logic                MISALIGN;

    // Control unit / branch logic side.
    modport master (
        output PC_LD, PC_SEL, JALR, BRANCH, JAL, MTVEC, MEPC, CALL, RET,
        input  PC_OUT, PC_PLUS, PC_NEXT, RAS_TOP, RAS_EMPTY, MISALIGN
    );

    // pc_gen side.
    modport slave (
        input  PC_LD, PC_SEL, JALR, BRANCH, JAL, MTVEC, MEPC, CALL, RET,
        output PC_OUT, PC_PLUS, PC_NEXT, RAS_TOP, RAS_EMPTY, MISALIGN
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack with a saturating occupancy count.
// When full, a push overwrites the oldest entry; pop on empty is ignored.
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next stack state: replace-top, push, or pop (push+pop on empty acts as push).
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && pop && (cnt_q != '0)) begin
            mem_d[ptr_q] = din;
        end else if (push) begin
            ptr_d        = ptr_q + PTR_W'(1);
            mem_d[ptr_d] = din;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stack registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign empty = (cnt_q == '0);
    assign top   = empty ? '0 : mem_q[ptr_q];

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: PC register, next-PC source mux, misaligned-target
// trap to MTVEC, and a return-address stack for call/return prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         STEP         = 4,
    parameter int unsigned         RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     RST,
    pc_gen_if.slave  bus
);
    localparam logic [PC_WIDTH-1:0] STEP_V     = PC_WIDTH'(STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(STEP - 1);
    localparam logic [PC_WIDTH-1:0] JALR_MASK  = ~PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                misalign_q, misalign_d;
    logic [PC_WIDTH-1:0] pc_plus;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_empty;
    logic                next_misaligned;
    logic                ras_push;
    logic                ras_pop;

    assign pc_plus         = pc_q + STEP_V;
    assign next_misaligned = |(pc_next & ALIGN_MASK);

    // Next-PC source select; reserved encoding and empty-stack return fall back to PC+STEP.
    always_comb begin
        pc_next = pc_plus;
        case (bus.PC_SEL)
            PC_SRC_JALR:   pc_next = bus.JALR & JALR_MASK;
            PC_SRC_BRANCH: pc_next = bus.BRANCH;
            PC_SRC_JAL:    pc_next = bus.JAL;
            PC_SRC_MTVEC:  pc_next = bus.MTVEC;
            PC_SRC_MEPC:   pc_next = bus.MEPC;
            PC_SRC_RAS:    pc_next = ras_empty ? pc_plus : ras_top;
            default:       pc_next = pc_plus;
        endcase
    end

    // Advance/stall/trap decision; the stack only moves on a clean advance.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (bus.PC_LD) begin
            if (next_misaligned) begin
                pc_d       = bus.MTVEC;
                misalign_d = 1'b1;
            end else begin
                pc_d     = pc_next;
                ras_push = bus.CALL;
                ras_pop  = bus.RET;
            end
        end
    end

    // PC and trap-pulse registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (RST),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus),
        .top   (ras_top),
        .empty (ras_empty)
    );

    assign bus.PC_OUT    = pc_q;
    assign bus.PC_PLUS   = pc_plus;
    assign bus.PC_NEXT   = pc_next;
    assign bus.RAS_TOP   = ras_top;
    assign bus.RAS_EMPTY = ras_empty;
    assign bus.MISALIGN  = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected PC values are queued as stimulus
// is applied and popped after each clock edge.
module tb_pc_gen;
    import pc_pkg::*;

    logic clk;
    logic RST;
    int   errors;
    int   checks;
    logic [31:0] exp_q[$];

    pc_gen_if #(.PC_WIDTH(32)) bus ();

    pc_gen #(
        .PC_WIDTH     (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.PC_LD  = 1'b1;
        bus.PC_SEL = PC_SRC_PLUS;
        bus.CALL   = 1'b0;
        bus.RET    = 1'b0;
        bus.JALR   = 32'hA00;
        bus.BRANCH = 32'hB00;
        bus.JAL    = 32'hC00;
        bus.MTVEC  = 32'hD00;
        bus.MEPC   = 32'hE00;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        checks++;
        if (bus.PC_OUT !== 32'h0 || bus.RAS_EMPTY !== 1'b1 || bus.MISALIGN !== 1'b0 || bus.RAS_TOP !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: pc=%h empty=%b mis=%b top=%h, want pc=0 empty=1 mis=0 top=0",
                     bus.PC_OUT, bus.RAS_EMPTY, bus.MISALIGN, bus.RAS_TOP);
        end
        clear_ctrl();
        tick();
        tick();
        checks++;
        if (bus.PC_OUT !== 32'h8) begin
            errors++;
            $display("FAIL pre_reset_pc: got %h want 00000008", bus.PC_OUT);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (bus.PC_OUT !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_pc: got %h want 00000000", bus.PC_OUT);
        end
        #1 RST = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'(i * 4));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (bus.PC_OUT !== exp) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: got %h want %h", i, bus.PC_OUT, exp);
            end
        end
        bus.PC_LD = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'hC);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (bus.PC_OUT !== exp) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, bus.PC_OUT, exp);
            end
        end
    endtask

    task automatic test_source_select();
        pc_src_t     sel_tab [7];
        logic [31:0] val_tab [7];
        logic [31:0] res_tab [7];
        logic [31:0] exp;
        sel_tab = '{PC_SRC_JAL, PC_SRC_JAL, PC_SRC_JALR, PC_SRC_MEPC, PC_SRC_RSVD, PC_SRC_BRANCH, PC_SRC_MTVEC};
        val_tab = '{32'h100, 32'h200, 32'h301, 32'h40, 32'h0, 32'h60, 32'h90};
        res_tab = '{32'h100, 32'h200, 32'h300, 32'h40, 32'h44, 32'h60, 32'h90};
        for (int i = 0; i < 7; i++) begin
            clear_ctrl();
            bus.PC_SEL = sel_tab[i];
            case (sel_tab[i])
                PC_SRC_JALR:   bus.JALR   = val_tab[i];
                PC_SRC_BRANCH: bus.BRANCH = val_tab[i];
                PC_SRC_JAL:    bus.JAL    = val_tab[i];
                PC_SRC_MTVEC:  bus.MTVEC  = val_tab[i];
                PC_SRC_MEPC:   bus.MEPC   = val_tab[i];
                default:       ;
            endcase
            exp_q.push_back(res_tab[i]);
            #1;
            checks++;
            if (bus.PC_NEXT !== res_tab[i]) begin
                errors++;
                $display("FAIL src_next[%0d]: got %h want %h", i, bus.PC_NEXT, res_tab[i]);
            end
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (bus.PC_OUT !== exp) begin
                errors++;
                $display("FAIL src_pc[%0d]: got %h want %h", i, bus.PC_OUT, exp);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp;
        clear_ctrl();
        bus.BRANCH = 32'h102;
        bus.MTVEC  = 32'h80;
        bus.PC_SEL = PC_SRC_BRANCH;
        bus.CALL   = 1'b1;
        exp_q.push_back(32'h80);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.MISALIGN !== 1'b1 || bus.RAS_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap: pc=%h mis=%b empty=%b, want pc=%h mis=1 empty=1",
                     bus.PC_OUT, bus.MISALIGN, bus.RAS_EMPTY, exp);
        end
        bus.CALL   = 1'b0;
        bus.PC_SEL = PC_SRC_PLUS;
        exp_q.push_back(32'h84);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.MISALIGN !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse_end: pc=%h mis=%b, want pc=%h mis=0", bus.PC_OUT, bus.MISALIGN, exp);
        end
        bus.PC_LD  = 1'b0;
        bus.PC_SEL = PC_SRC_BRANCH;
        exp_q.push_back(32'h84);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.MISALIGN !== 1'b0) begin
            errors++;
            $display("FAIL misalign_stalled: pc=%h mis=%b, want pc=%h mis=0", bus.PC_OUT, bus.MISALIGN, exp);
        end
    endtask

    task automatic test_ras_call_ret();
        logic [31:0] exp;
        clear_ctrl();
        bus.PC_SEL = PC_SRC_JAL;
        bus.JAL    = 32'h10;
        tick();
        bus.JAL  = 32'h400;
        bus.CALL = 1'b1;
        exp_q.push_back(32'h400);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_TOP !== 32'h14 || bus.RAS_EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL ras_call: pc=%h top=%h empty=%b, want pc=%h top=00000014 empty=0",
                     bus.PC_OUT, bus.RAS_TOP, bus.RAS_EMPTY, exp);
        end
        bus.CALL   = 1'b0;
        bus.RET    = 1'b1;
        bus.PC_SEL = PC_SRC_RAS;
        exp_q.push_back(32'h14);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL ras_ret: pc=%h empty=%b, want pc=%h empty=1", bus.PC_OUT, bus.RAS_EMPTY, exp);
        end
        exp_q.push_back(32'h18);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_EMPTY !== 1'b1 || bus.RAS_TOP !== 32'h0) begin
            errors++;
            $display("FAIL ras_ret_empty: pc=%h empty=%b top=%h, want pc=%h empty=1 top=0",
                     bus.PC_OUT, bus.RAS_EMPTY, bus.RAS_TOP, exp);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp;
        clear_ctrl();
        bus.PC_SEL = PC_SRC_JAL;
        bus.JAL    = 32'h0;
        tick();
        bus.PC_SEL = PC_SRC_PLUS;
        bus.CALL   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(32'(i * 4));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (bus.PC_OUT !== exp || bus.RAS_TOP !== exp) begin
                errors++;
                $display("FAIL ovf_push[%0d]: pc=%h top=%h, want both %h", i, bus.PC_OUT, bus.RAS_TOP, exp);
            end
        end
        bus.CALL   = 1'b0;
        bus.RET    = 1'b1;
        bus.PC_SEL = PC_SRC_RAS;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h14 - 32'(i * 4));
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (bus.PC_OUT !== exp) begin
                errors++;
                $display("FAIL ovf_pop[%0d]: got %h want %h", i, bus.PC_OUT, exp);
            end
        end
        checks++;
        if (bus.RAS_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: got empty=%b want 1", bus.RAS_EMPTY);
        end
    endtask

    task automatic test_back_to_back_call_ret();
        logic [31:0] exp;
        clear_ctrl();
        bus.PC_SEL = PC_SRC_JAL;
        bus.JAL    = 32'h1C;
        tick();
        bus.JAL  = 32'h50;
        bus.CALL = 1'b1;
        tick();
        checks++;
        if (bus.PC_OUT !== 32'h50 || bus.RAS_TOP !== 32'h20) begin
            errors++;
            $display("FAIL cr_setup: pc=%h top=%h, want pc=00000050 top=00000020", bus.PC_OUT, bus.RAS_TOP);
        end
        bus.RET    = 1'b1;
        bus.PC_SEL = PC_SRC_PLUS;
        exp_q.push_back(32'h54);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_TOP !== 32'h54 || bus.RAS_EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL cr_replace: pc=%h top=%h empty=%b, want pc=%h top=00000054 empty=0",
                     bus.PC_OUT, bus.RAS_TOP, bus.RAS_EMPTY, exp);
        end
        bus.PC_LD = 1'b0;
        exp_q.push_back(32'h54);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_TOP !== 32'h54) begin
            errors++;
            $display("FAIL cr_stalled: pc=%h top=%h, want pc=%h top=00000054", bus.PC_OUT, bus.RAS_TOP, exp);
        end
        bus.PC_LD  = 1'b1;
        bus.CALL   = 1'b0;
        bus.PC_SEL = PC_SRC_RAS;
        exp_q.push_back(32'h54);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.RAS_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL cr_count_one: pc=%h empty=%b, want pc=%h empty=1", bus.PC_OUT, bus.RAS_EMPTY, exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        clear_ctrl();
        bus.PC_SEL = PC_SRC_JAL;
        bus.JAL    = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (bus.PC_PLUS !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus: got %h want 00000000", bus.PC_PLUS);
        end
        bus.PC_SEL = PC_SRC_PLUS;
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (bus.PC_OUT !== exp || bus.MISALIGN !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h mis=%b, want pc=%h mis=0", bus.PC_OUT, bus.MISALIGN, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST    = 1'b1;
        clear_ctrl();
        bus.PC_LD = 1'b0;
        #12;
        RST = 1'b0;
        test_reset();
        test_source_select();
        test_misalign();
        test_ras_call_ret();
        test_ras_overflow();
        test_back_to_back_call_ret();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter unit for the OTTER MCU fetch stage; next generation of the plain 10-bit loadable PC.
- Holds the PC and selects the next PC from seven sources.
- Adds stall, misaligned-target trapping, and a small circular return-address stack (RAS) for call/return.
- Sits between the control unit / branch logic and instruction memory address.

Parameters:
- PC_WIDTH, 32, width of PC and all address buses (≥ 8).
- RESET_VECTOR, 0, PC value after reset; must be a multiple of STEP.
- STEP, 4, sequential increment in bytes; power of two, ≥ 2.
- RAS_DEPTH, 4, number of return-address entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- PC_LD  in  1  advance enable; 0 = stall, hold all state.
- PC_SEL  in  3  next-PC source, pc_src_t.
- JALR  in  PC_WIDTH  jalr target.
- BRANCH  in  PC_WIDTH  branch target.
- JAL  in  PC_WIDTH  jal target.
- MTVEC  in  PC_WIDTH  trap vector.
- MEPC  in  PC_WIDTH  trap return address.
- CALL  in  1  current instruction is a call; push on advance.
- RET  in  1  current instruction is a return; pop on advance.
- PC_OUT  out  PC_WIDTH  registered current PC.
- PC_PLUS  out  PC_WIDTH  PC_OUT + STEP, combinational.
- PC_NEXT  out  PC_WIDTH  selected next PC, combinational.
- RAS_TOP  out  PC_WIDTH  top RAS entry; 0 when empty.
- RAS_EMPTY  out  1  RAS holds no entries.
- MISALIGN  out  1  registered one-cycle trap pulse.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - PC_OUT = RESET_VECTOR.
  - RAS count = 0, pointer = 0, RAS_EMPTY = 1.
  - MISALIGN = 0.
- PC_SEL encoding:
  - 0 PLUS, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6 RAS.
  - 7 is reserved and behaves as PLUS.
  - For JALR, bit 0 of the target is cleared before use.
  - For RAS when the stack is empty, PC_NEXT = PC_PLUS.
- Arithmetic: PC_PLUS wraps modulo 2^PC_WIDTH; no overflow flag.
- Misalignment: PC_NEXT is misaligned when PC_NEXT mod STEP ≠ 0.
- Rising edge with PC_LD=0: PC_OUT, RAS and pointer hold; MISALIGN <= 0.
- Rising edge with PC_LD=1 and PC_NEXT aligned:
  - PC_OUT <= PC_NEXT; MISALIGN <= 0.
- Rising edge with PC_LD=1 and PC_NEXT misaligned:
  - PC_OUT <= MTVEC; MISALIGN <= 1 for exactly one cycle.
  - RAS is not modified, even if CALL or RET is asserted.
- Latency: new PC is visible on PC_OUT one cycle after the advancing edge. No combinational path from any input to PC_OUT.
- RAS operation (only on an advancing, non-trapping edge):
  - CALL only: push PC_PLUS; count saturates at RAS_DEPTH. When full, the oldest entry is overwritten (circular pointer).
  - RET only: pop; when empty, this is a no-op and count stays 0.
  - CALL and RET together: top entry is replaced with PC_PLUS; count unchanged. If empty, behaves as a push.
  - RAS_TOP and RAS_EMPTY are combinational from registered state.
- Control inputs are don't-care while RST is high.

Decomposition:
- Package pc_pkg holds:
  - typedef enum logic [2:0] pc_src_t {PC_SRC_PLUS, PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL, PC_SRC_MTVEC, PC_SRC_MEPC, PC_SRC_RAS, PC_SRC_RSVD}.
  - localparam PC_SRC_W = 3.
- Sub-module ras_stack, parametrised on WIDTH and DEPTH:
  - inputs push, pop, din; outputs top, empty.
  - circular pointer plus saturating count.
  - the push/pop gating (advance, no trap) is done in pc_gen.
- pc_gen contains the PC register, next-PC mux, misalign check and trap override.

Test Plan:
- Reset and sequential fetch: RST pulse mid-cycle, then PC_LD=1, PC_SEL=PLUS for 3 edges → PC_OUT is 0 asynchronously on reset, then 4, 8, 12. With PC_LD=0 for 2 edges, PC_OUT holds 12.
- Source select: from PC=0x100, PC_SEL=JAL with JAL=0x200 → 0x200. Then JALR=0x301 → 0x300 (bit 0 cleared). Then MEPC=0x40 → 0x40. Then PC_SEL=7 → 0x44.
- Misaligned branch: BRANCH=0x102, MTVEC=0x80, PC_SEL=BRANCH, CALL=1 → PC_OUT=0x80, MISALIGN=1 for one cycle only, RAS_EMPTY still 1.
- RAS call/return: from PC=0x10, CALL with PC_SEL=JAL to 0x400 → RAS_TOP=0x14. Then RET with PC_SEL=RAS → PC_OUT=0x14, RAS_EMPTY=1. A second RET → PC_OUT=0x18 and the stack stays empty.
- RAS overflow (RAS_DEPTH=4): 5 calls pushing 0x4, 0x8, 0xC, 0x10, 0x14, then 4 pops → pops return 0x14, 0x10, 0xC, 0x8, then RAS_EMPTY=1 (0x4 was lost to the overwrite).
- Simultaneous CALL+RET with 1 entry (0x20) and PC_PLUS=0x54 → RAS_TOP=0x54, count stays 1. Repeating with PC_LD=0 → no change.
